// File: rtl/ldpc_ber_tester_dout_checker.sv
// Bit-error checker on the LDPC decoder DOUT stream. The all-zero codeword is assumed,
// so every set bit is an error. Counts bit/block/framing errors and drives dout_finish.
module ldpc_ber_tester_dout_checker #(
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          sw_resetn,
    input  logic [15:0]                   dout_beats,
    input  logic [$clog2(DATA_WIDTH):0]   last_valid_bits,
    input  logic                          dout_valid,
    output logic                          dout_ready,
    input  logic [DATA_WIDTH-1:0]         dout_data,
    input  logic                          dout_last,
    output logic                          dout_finish,
    output logic [63:0]                   bit_errors,
    output logic [31:0]                   block_errors,
    output logic [63:0]                   checked_blocks,
    output logic [15:0]                   framing_errors
);

    localparam int unsigned LVLS = $clog2(DATA_WIDTH);
    localparam int unsigned PCW  = LVLS + 1;

    logic                  ready_q, ready_d;
    logic                  v1_q, v1_d;
    logic                  l1_q, l1_d;
    logic [PCW-1:0]        pc1_q, pc1_d;
    logic [63:0]           bit_errors_q, bit_errors_d;
    logic [31:0]           blk_acc_q, blk_acc_d;
    logic [31:0]           block_errors_q, block_errors_d;
    logic [63:0]           checked_q, checked_d;
    logic [15:0]           framing_q, framing_d;
    logic [15:0]           cnt_q, cnt_d;

    logic                  accept;
    logic                  partial;
    logic [DATA_WIDTH-1:0] mask;
    logic [DATA_WIDTH-1:0] masked;
    logic [PCW-1:0]        popcnt;
    logic [PCW-1:0]        tree [LVLS+1][DATA_WIDTH];
    logic [32:0]           blk_sum;
    logic [31:0]           blk_sat;

    assign accept      = dout_valid & ready_q;
    assign dout_finish = accept & dout_last;

    // Only the tlast beat is trimmed; counts above DATA_WIDTH behave like 0 (full beat).
    always_comb begin
        partial = dout_last && (last_valid_bits != '0) && (last_valid_bits < PCW'(DATA_WIDTH));
        for (int i = 0; i < DATA_WIDTH; i++) begin
            mask[i] = !partial || (PCW'(i) < last_valid_bits);
        end
        masked = dout_data & mask;
    end

    // Balanced pairwise adder tree: level l holds DATA_WIDTH>>l partial sums.
    always_comb begin
        for (int l = 0; l <= LVLS; l++) begin
            for (int i = 0; i < DATA_WIDTH; i++) begin
                tree[l][i] = '0;
            end
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            tree[0][i] = PCW'(masked[i]);
        end
        for (int l = 1; l <= LVLS; l++) begin
            for (int i = 0; i < (DATA_WIDTH >> l); i++) begin
                tree[l][i] = tree[l-1][2*i] + tree[l-1][2*i+1];
            end
        end
        popcnt = tree[LVLS][0];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ready_q        <= 1'b0;
            v1_q           <= 1'b0;
            l1_q           <= 1'b0;
            pc1_q          <= '0;
            bit_errors_q   <= '0;
            blk_acc_q      <= '0;
            block_errors_q <= '0;
            checked_q      <= '0;
            framing_q      <= '0;
            cnt_q          <= '0;
        end else begin
            ready_q        <= ready_d;
            v1_q           <= v1_d;
            l1_q           <= l1_d;
            pc1_q          <= pc1_d;
            bit_errors_q   <= bit_errors_d;
            blk_acc_q      <= blk_acc_d;
            block_errors_q <= block_errors_d;
            checked_q      <= checked_d;
            framing_q      <= framing_d;
            cnt_q          <= cnt_d;
        end
    end

    always_comb begin
        ready_d        = 1'b1;
        v1_d           = accept & sw_resetn;
        l1_d           = dout_last;
        pc1_d          = popcnt;
        bit_errors_d   = bit_errors_q;
        blk_acc_d      = blk_acc_q;
        block_errors_d = block_errors_q;
        checked_d      = checked_q;
        framing_d      = framing_q;
        cnt_d          = cnt_q;

        blk_sum = 33'(blk_acc_q) + 33'(pc1_q);
        blk_sat = blk_sum[32] ? 32'hFFFF_FFFF : blk_sum[31:0];

        // Stage 2: accumulate the registered popcount, close the block on its last beat.
        if (v1_q) begin
            bit_errors_d = bit_errors_q + 64'(pc1_q);
            if (l1_q) begin
                checked_d = checked_q + 64'd1;
                if ((blk_sat != '0) && (block_errors_q != 32'hFFFF_FFFF)) begin
                    block_errors_d = block_errors_q + 32'd1;
                end
                blk_acc_d = '0;
            end else begin
                blk_acc_d = blk_sat;
            end
        end

        // Beat counter runs in the accept cycle so framing shows one cycle after tlast.
        if (accept) begin
            if (dout_last) begin
                if (((17'(cnt_q) + 17'd1) != 17'(dout_beats)) && (framing_q != 16'hFFFF)) begin
                    framing_d = framing_q + 16'd1;
                end
                cnt_d = '0;
            end else if (cnt_q != 16'hFFFF) begin
                cnt_d = cnt_q + 16'd1;
            end
        end

        if (!sw_resetn) begin
            v1_d           = 1'b0;
            l1_d           = 1'b0;
            pc1_d          = '0;
            bit_errors_d   = '0;
            blk_acc_d      = '0;
            block_errors_d = '0;
            checked_d      = '0;
            framing_d      = '0;
            cnt_d          = '0;
        end
    end

    assign dout_ready     = ready_q;
    assign bit_errors     = bit_errors_q;
    assign block_errors   = block_errors_q;
    assign checked_blocks = checked_q;
    assign framing_errors = framing_q;

endmodule

// File: tb/tb_ldpc_ber_tester_dout_checker.sv
// Scoreboard bench for ldpc_ber_tester_dout_checker: a behavioural model queues the expected
// counters at each tlast and a negedge monitor compares them when they are due.
module tb_ldpc_ber_tester_dout_checker;

    localparam int unsigned DW = 128;
    localparam int unsigned PW = $clog2(DW) + 1;

    logic          clk = 1'b0;
    logic          resetn;
    logic          sw_resetn;
    logic [15:0]   dout_beats;
    logic [PW-1:0] last_valid_bits;
    logic          dout_valid;
    logic          dout_ready;
    logic [DW-1:0] dout_data;
    logic          dout_last;
    logic          dout_finish;
    logic [63:0]   bit_errors;
    logic [31:0]   block_errors;
    logic [63:0]   checked_blocks;
    logic [15:0]   framing_errors;

    always #5 clk = ~clk;

    ldpc_ber_tester_dout_checker #(.DATA_WIDTH(DW)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .sw_resetn       (sw_resetn),
        .dout_beats      (dout_beats),
        .last_valid_bits (last_valid_bits),
        .dout_valid      (dout_valid),
        .dout_ready      (dout_ready),
        .dout_data       (dout_data),
        .dout_last       (dout_last),
        .dout_finish     (dout_finish),
        .bit_errors      (bit_errors),
        .block_errors    (block_errors),
        .checked_blocks  (checked_blocks),
        .framing_errors  (framing_errors)
    );

    typedef struct {
        int unsigned due;
        logic [63:0] bits;
        logic [31:0] blk;
        logic [63:0] chk;
    } stat_t;

    typedef struct {
        int unsigned due;
        logic [15:0] fe;
    } fe_t;

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned cyc     = 0;
    logic        exp_ready = 1'b0;
    logic        exp_fin   = 1'b0;

    logic [63:0] m_bits;
    logic [31:0] m_blk;
    logic [63:0] m_chk;
    logic [15:0] m_fe;
    int unsigned m_cnt;
    longint unsigned m_acc;

    stat_t sq[$];
    fe_t   fq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: per-cycle handshake checks plus scoreboard pops at their due cycle.
    always @(negedge clk) begin : mon
        fe_t   f;
        stat_t s;
        check_eq("ready", 64'(dout_ready), 64'(exp_ready));
        check_eq("finish", 64'(dout_finish), 64'(exp_fin));
        while (fq.size() > 0 && fq[0].due <= cyc) begin
            f = fq.pop_front();
            check_eq("sb.framing", 64'(framing_errors), 64'(f.fe));
        end
        while (sq.size() > 0 && sq[0].due <= cyc) begin
            s = sq.pop_front();
            check_eq("sb.bits", bit_errors, s.bits);
            check_eq("sb.blk", 64'(block_errors), 64'(s.blk));
            check_eq("sb.chk", checked_blocks, s.chk);
        end
    end

    task automatic model_zero();
        m_bits = '0; m_blk = '0; m_chk = '0; m_fe = '0; m_cnt = 0; m_acc = 0;
        fq.delete();
        sq.delete();
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input logic l, input logic [PW-1:0] n);
        int unsigned lim;
        int unsigned pc;
        lim = (l && n != '0 && 32'(n) <= DW) ? 32'(n) : DW;
        pc = 0;
        for (int i = 0; i < int'(lim); i++) if (d[i]) pc++;
        m_bits = m_bits + 64'(pc);
        m_acc  = m_acc + 64'(pc);
        if (m_acc > 64'hFFFF_FFFF) m_acc = 64'hFFFF_FFFF;
        if (l) begin
            m_chk = m_chk + 64'd1;
            if (m_acc != 0 && m_blk != 32'hFFFF_FFFF) m_blk = m_blk + 32'd1;
            m_acc = 0;
            if (m_cnt + 1 != 32'(dout_beats) && m_fe != 16'hFFFF) m_fe = m_fe + 16'd1;
            m_cnt = 0;
            fq.push_back('{due: cyc + 1, fe: m_fe});
            sq.push_back('{due: cyc + 2, bits: m_bits, blk: m_blk, chk: m_chk});
        end else if (m_cnt != 65535) begin
            m_cnt++;
        end
    endtask

    // One clock of stimulus; returns 1 time unit after the edge that samples it.
    task automatic drive(input logic v, input logic [DW-1:0] d, input logic l, input logic [PW-1:0] n);
        dout_valid = v; dout_data = d; dout_last = l; last_valid_bits = n;
        exp_fin = v & l & exp_ready;
        if (v && exp_ready && sw_resetn) model_beat(d, l, n);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0);
    endtask

    task automatic send_block(input int nb, input logic [DW-1:0] d, input logic [DW-1:0] d_last,
                              input logic [PW-1:0] n);
        for (int j = 0; j < nb - 1; j++) drive(1'b1, d, 1'b0, '0);
        drive(1'b1, d_last, 1'b1, n);
    endtask

    task automatic sw_clear();
        sw_resetn = 1'b0;
        model_zero();
        idle(2);
        sw_resetn = 1'b1;
    endtask

    task automatic expect_totals(input string tag, input logic [63:0] b, input logic [31:0] be,
                                 input logic [63:0] c, input logic [15:0] f);
        check_eq({tag, ".bits"}, bit_errors, b);
        check_eq({tag, ".blk"}, 64'(block_errors), 64'(be));
        check_eq({tag, ".chk"}, checked_blocks, c);
        check_eq({tag, ".fe"}, 64'(framing_errors), 64'(f));
    endtask

    function automatic logic [DW-1:0] rand_beat();
        logic [DW-1:0] d;
        int unsigned k;
        d = '0;
        k = $urandom_range(0, 3);
        if (k == 1) d[$urandom_range(0, DW - 1)] = 1'b1;
        else if (k == 2) for (int i = 0; i < int'(DW / 32); i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    logic [DW-1:0] ones;
    logic [DW-1:0] one_bit;

    initial begin
        ones    = '1;
        one_bit = DW'(1);
        resetn = 1'b0; sw_resetn = 1'b1; dout_beats = 16'd4;
        model_zero();

        // Reset: valid+last held high, nothing may be accepted.
        for (int i = 0; i < 3; i++) drive(1'b1, ones, 1'b1, '0);
        check_eq("rst.ready", 64'(dout_ready), 64'd0);
        check_eq("rst.finish", 64'(dout_finish), 64'd0);
        expect_totals("rst", 64'd0, 32'd0, 64'd0, 16'd0);
        resetn = 1'b1;
        idle(1);
        exp_ready = 1'b1;

        // Zero-error blocks, back to back.
        for (int b = 0; b < 3; b++) send_block(4, '0, '0, '0);
        idle(3);
        expect_totals("zero", 64'd0, 32'd0, 64'd3, 16'd0);

        // Error counting with exact 2-cycle latency.
        sw_clear();
        dout_beats = 16'd2;
        drive(1'b1, DW'(8'hFF), 1'b0, '0);
        drive(1'b1, DW'(1), 1'b1, '0);
        check_eq("err.bits_early", bit_errors, 64'd8);
        idle(1);
        check_eq("err.bits_due", bit_errors, 64'd9);
        idle(2);
        expect_totals("err", 64'd9, 32'd1, 64'd1, 16'd0);

        // Masking of the tlast beat.
        sw_clear();
        dout_beats = 16'd1;
        send_block(1, '0, ones, PW'(5));
        idle(3);
        check_eq("mask.5", bit_errors, 64'd5);
        send_block(1, '0, ones, '0);
        idle(3);
        check_eq("mask.0", bit_errors, 64'(5 + DW));
        send_block(1, '0, ones, PW'(DW + 7));
        dout_beats = 16'd2;
        send_block(2, ones, '0, PW'(3));
        idle(3);
        expect_totals("mask", 64'(5 + 3 * DW), 32'd4, 64'd4, 16'd0);

        // Framing: short, long (merged), then correct block; dout_beats=0 flags everything.
        sw_clear();
        dout_beats = 16'd4;
        send_block(3, '0, '0, '0);
        send_block(6, '0, '0, '0);
        idle(3);
        expect_totals("frm", 64'd0, 32'd0, 64'd2, 16'd2);
        send_block(4, '0, '0, '0);
        idle(3);
        expect_totals("frm.ok", 64'd0, 32'd0, 64'd3, 16'd2);
        dout_beats = 16'd0;
        send_block(1, '0, '0, '0);
        idle(3);
        check_eq("frm.zero_beats", 64'(framing_errors), 64'd3);

        // Software clear mid-block while beats keep flowing.
        dout_beats = 16'd4;
        drive(1'b1, one_bit, 1'b0, '0);
        drive(1'b1, one_bit, 1'b0, '0);
        sw_resetn = 1'b0;
        model_zero();
        drive(1'b1, one_bit, 1'b0, '0);
        expect_totals("swlow", 64'd0, 32'd0, 64'd0, 16'd0);
        drive(1'b1, one_bit, 1'b1, '0);
        idle(3);
        expect_totals("swlow.end", 64'd0, 32'd0, 64'd0, 16'd0);
        check_eq("swlow.ready", 64'(dout_ready), 64'd1);
        sw_resetn = 1'b1;
        send_block(4, '0, one_bit, '0);
        idle(3);
        expect_totals("swrel", 64'd1, 32'd1, 64'd1, 16'd0);

        // block_errors saturation.
        sw_clear();
        dout_beats = 16'd1;
        force dut.block_errors_q = 32'hFFFF_FFFE;
        #1;
        release dut.block_errors_q;
        m_blk = 32'hFFFF_FFFE;
        check_eq("sat.preset", 64'(block_errors), 64'h0000_0000_FFFF_FFFE);
        for (int b = 0; b < 3; b++) send_block(1, '0, DW'(3), '0);
        idle(3);
        expect_totals("sat", 64'd6, 32'hFFFF_FFFF, 64'd3, 16'd0);

        // Random valid throttling over 100 blocks of random length.
        sw_clear();
        dout_beats = 16'd3;
        for (int b = 0; b < 100; b++) begin
            int unsigned nb;
            nb = $urandom_range(1, 5);
            for (int j = 0; j < int'(nb); j++) begin
                while ($urandom_range(0, 3) == 0) idle(1);
                drive(1'b1, rand_beat(), (j == int'(nb) - 1), PW'($urandom_range(0, (1 << PW) - 1)));
            end
        end
        idle(4);
        expect_totals("rand", m_bits, m_blk, m_chk, m_fe);
        check_eq("rand.chk_count", checked_blocks, 64'd100);
        check_eq("sq.drained", 64'(sq.size()), 64'd0);
        check_eq("fq.drained", 64'(fq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/ldpc_ber_tester_dout_checker.md
# ldpc_ber_tester_dout_checker

Bit-error checker that sits directly downstream of the LDPC decoder's DOUT AXI-Stream and consumes every decoded block. Because the tester transmits the all-zero codeword, every set bit in a decoded beat is a bit error. The block counts bit errors, block errors and framing errors, and generates the `dout_finish` pulse that the BER tester control block uses to retire in-flight transactions.

## Interface
- `DATA_WIDTH`, 128: DOUT beat width in bits; power of two, 32..512.
- `clk`  in  1  clock.
- `resetn`  in  1  reset; synchronous, active-low.
- `sw_resetn`  in  1  software counter clear; synchronous, active-low.
- `dout_beats`  in  16  expected beats per decoded block.
- `last_valid_bits`  in  `$clog2(DATA_WIDTH)+1`  valid LSBs in the tlast beat; 0 means all `DATA_WIDTH` bits are valid.
- `dout_valid`  in  1  AXI-S valid from the decoder.
- `dout_ready`  out  1  AXI-S ready, registered.
- `dout_data`  in  `DATA_WIDTH`  decoded hard bits.
- `dout_last`  in  1  AXI-S tlast.
- `dout_finish`  out  1  combinational: `dout_valid & dout_ready & dout_last`.
- `bit_errors`  out  64  total erroneous bits.
- `block_errors`  out  32  blocks with at least one bit error.
- `checked_blocks`  out  64  blocks whose errors have been accumulated.
- `framing_errors`  out  16  blocks whose length differs from `dout_beats`.

## Operation
- **Ready.** `dout_ready` is 0 in reset. It becomes 1 on the first clock edge with `resetn` high and stays 1; the checker never backpressures. A beat is *accepted* when `dout_valid & dout_ready`.
- **Masking.** On an accepted beat with `dout_last=1` and `last_valid_bits=N≠0`, only bits [N-1:0] are checked. Values of N above `DATA_WIDTH` are treated as 0. Non-last beats are always checked in full.
- **Stage 1 (registered).**
  - `pc1` = popcount of the masked beat; `v1` = accepted; `l1` = `dout_last`.
  - Popcount is a balanced adder tree, with width `$clog2(DATA_WIDTH)+1`.
- **Stage 2 (on `v1`).**
  - `bit_errors += pc1`, wrapping.
  - `blk_acc += pc1`; `blk_acc` is 32-bit and saturating.
  - If `l1`:
    - `checked_blocks += 1`.
    - If `blk_acc + pc1 ≠ 0`, `block_errors += 1`, saturating at 0xFFFFFFFF.
    - `blk_acc <= 0`.
- **Beat counter `cnt`** (16-bit, saturating at 0xFFFF).
  - On an accepted beat without tlast: `cnt += 1`.
  - On an accepted beat with tlast: if `cnt + 1 ≠ dout_beats` (17-bit compare), `framing_errors += 1`, saturating at 0xFFFF. Then `cnt <= 0`.
  - `dout_beats = 0` flags every block.
  - A missing tlast is detected only when the next tlast arrives: one framing error is counted for the merged block.
- **sw_resetn low.**
  - All counters, `cnt`, `blk_acc` and pipeline valids are held at 0.
  - Beats are still accepted and discarded.
  - `dout_finish` is still generated, so the control block's in-flight count stays consistent.
  - On release, counting starts with the first beat accepted at or after the release edge.
- **Simultaneous events.** An accepted beat in the same cycle as a stage-2 update is normal pipelining; both take effect, with no stall or loss.

## Timing
- Reset values:
  - `dout_ready`, `bit_errors`, `block_errors`, `checked_blocks`, `framing_errors`, `cnt`, `blk_acc`, `v1`, `l1`, `pc1`: all 0.
  - `dout_finish` is 0 because `dout_ready` is 0.
- `dout_finish` has zero latency, in the same cycle as the accepted tlast beat.
- `framing_errors` updates 1 cycle after the tlast beat is accepted.
- `bit_errors`, `block_errors` and `checked_blocks` reflect an accepted beat 2 cycles after acceptance.
- Throughput is one beat per clock sustained, with no bubbles required between blocks.
- Reset mid-block: `resetn` or `sw_resetn` low discards any partial-block state. The next block is counted from its first beat after release.

## Test plan
- **Zero-error blocks.** Reset, then 3 blocks of 4 zero beats, `dout_beats=4`, valid held high → `dout_finish` pulses on beats 4, 8 and 12; `checked_blocks=3`, `bit_errors=0`, `block_errors=0`, `framing_errors=0`.
- **Error counting.** One block of 2 beats carrying 0xFF and 0x1 with the other bits zero, `last_valid_bits=0` → `bit_errors=9` exactly 2 cycles after the last beat; `block_errors=1`.
- **Masking.** Last beat all-ones, `last_valid_bits=5` → that beat contributes 5 bits. With `last_valid_bits=0` → it contributes `DATA_WIDTH` bits.
- **Framing.** `dout_beats=4`; send a block of 3 beats, then a block of 6 beats → `framing_errors=2`, `checked_blocks=2`. A following 4-beat block leaves `framing_errors=2`.
- **Software clear.** Pull `sw_resetn` low for 5 cycles mid-block while beats flow → counters read 0, `dout_finish` still pulses on tlast, and `dout_ready` stays 1. After release, a 1-error block gives `bit_errors=1` and `checked_blocks=1`.
- **Saturation and throttling.** Force `block_errors` to 0xFFFFFFFE and send 3 erroneous blocks → `block_errors` holds at 0xFFFFFFFF. Separately, randomly toggle `dout_valid` across 100 blocks → totals match the scoreboard.
